// File: rtl/mips_uart_loader.sv
// UART (8N1) program loader for the multicycle MIPS core: receives a count byte plus an image,
// writes words from address 0 while the CPU is halted, then resets and releases it.
// Optional build macro LOADER_CHECKSUM_EN: expects a trailing XOR checksum byte before release.
module mips_uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MEM_WORDS    = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        cpu_halt,
    output logic        cpu_rst,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [6:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        err,
    output logic [7:0]  words_loaded
);

    // state     | meaning
    // R_IDLE    | line idle, waiting for a falling edge
    // R_START   | half-bit wait, re-check start bit
    // R_DATA    | sampling 8 data bits LSB first
    // R_STOP    | waiting for mid-stop-bit sample
    // L_IDLE    | waiting for a valid count byte
    // L_DATA    | collecting bytes of the current word (or the checksum)
    // L_WRITE   | single memory write cycle
    // L_RELEASE | two-cycle CPU reset pulse, CPU still halted

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] TMR_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] TMR_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]       MAX_N    = 8'(MEM_WORDS);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {L_IDLE, L_DATA, L_WRITE, L_RELEASE} ld_state_t;

    logic             rx_s1, rx_s2, rx_d;
    logic             rx_fall;
    rx_state_t        r_state, r_next;
    logic [CNT_W-1:0] tmr;
    logic             tmr_zero;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_byte;
    logic             byte_valid, ferr;

    ld_state_t        l_state, l_next;
    logic [1:0]       byte_cnt;
    logic [7:0]       count_n;
    logic             rel_cnt;
    logic             cnt_bad;
    logic             last_word;
    logic             csum_phase;
    logic             csum_ok;

    // Sync flops reset high so reset release never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign rx_fall  = rx_d & ~rx_s2;
    assign tmr_zero = (tmr == '0);

    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (rx_fall) r_next = R_START;
            R_START: if (tmr_zero) r_next = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (tmr_zero && bit_idx == 3'd7) r_next = R_STOP;
            R_STOP:  if (tmr_zero) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = (r_state == R_STOP) && tmr_zero && rx_s2;
        ferr       = (r_state == R_STOP) && tmr_zero && !rx_s2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr     <= '0;
            bit_idx <= '0;
            rx_byte <= '0;
        end else begin
            case (r_state)
                R_IDLE: tmr <= TMR_HALF;
                R_START: begin
                    if (tmr_zero) begin
                        tmr     <= TMR_FULL;
                        bit_idx <= '0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                R_DATA: begin
                    if (tmr_zero) begin
                        rx_byte <= {rx_s2, rx_byte[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        tmr     <= TMR_FULL;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: tmr <= tmr - 1'b1;
            endcase
        end
    end

    assign cnt_bad   = (rx_byte == 8'd0) || (rx_byte > MAX_N);
    assign last_word = ((words_loaded + 8'd1) == count_n);

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;
    assign csum_phase = (words_loaded == count_n);
    assign csum_ok    = (rx_byte == csum);
`else
    assign csum_phase = 1'b0;
    assign csum_ok    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) l_state <= L_IDLE;
        else     l_state <= l_next;
    end

    always_comb begin
        l_next = l_state;
        case (l_state)
            L_IDLE: if (byte_valid && !cnt_bad) l_next = L_DATA;
            L_DATA: begin
                if (ferr) begin
                    l_next = L_IDLE;
                end else if (byte_valid) begin
                    if (csum_phase)              l_next = csum_ok ? L_RELEASE : L_IDLE;
                    else if (byte_cnt == 2'd3)   l_next = L_WRITE;
                end
            end
            L_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
                l_next = L_DATA;
`else
                l_next = last_word ? L_RELEASE : L_DATA;
`endif
            end
            L_RELEASE: if (rel_cnt) l_next = L_IDLE;
            default:   l_next = L_IDLE;
        endcase
    end

    always_comb begin
        mem_cs  = (l_state == L_WRITE);
        mem_we  = (l_state == L_WRITE);
        cpu_rst = (l_state == L_RELEASE);
    end

    // mem_addr holds at N-1 after the final word so it never wraps within a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_halt     <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            byte_cnt     <= '0;
            count_n      <= '0;
            rel_cnt      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            case (l_state)
                L_IDLE: begin
                    if (byte_valid) begin
                        if (cnt_bad) begin
                            err <= 1'b1;
                        end else begin
                            cpu_halt     <= 1'b1;
                            busy         <= 1'b1;
                            err          <= 1'b0;
                            words_loaded <= '0;
                            mem_addr     <= '0;
                            count_n      <= rx_byte;
                            byte_cnt     <= '0;
`ifdef LOADER_CHECKSUM_EN
                            csum         <= '0;
`endif
                        end
                    end else if (ferr) begin
                        err <= 1'b1;
                    end
                end
                L_DATA: begin
                    if (ferr) begin
                        err  <= 1'b1;
                        busy <= 1'b0;
                    end else if (byte_valid) begin
                        if (csum_phase) begin
                            if (!csum_ok) begin
                                err  <= 1'b1;
                                busy <= 1'b0;
                            end
                        end else begin
                            mem_wdata <= {mem_wdata[23:0], rx_byte};
                            byte_cnt  <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                            csum      <= csum ^ rx_byte;
`endif
                        end
                    end
                end
                L_WRITE: begin
                    words_loaded <= words_loaded + 8'd1;
                    if (!last_word) mem_addr <= mem_addr + 7'd1;
                end
                L_RELEASE: begin
                    if (rel_cnt) begin
                        cpu_halt <= 1'b0;
                        busy     <= 1'b0;
                        rel_cnt  <= 1'b0;
                    end else begin
                        rel_cnt <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_uart_loader.sv
// Self-checking bench for mips_uart_loader: table-driven count-byte cases, random images
// checked against an image-level model, plus hand-written corner sequences.
module tb_mips_uart_loader;
    localparam int CPB = 4;
    localparam int MW  = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        cpu_halt, cpu_rst, mem_cs, mem_we, busy, err;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  words_loaded;

    always #5 clk = ~clk;

    mips_uart_loader #(.CLKS_PER_BIT(CPB), .MEM_WORDS(MW)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .cpu_halt(cpu_halt), .cpu_rst(cpu_rst),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .err(err), .words_loaded(words_loaded)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus monitor: records every write, cpu_rst cycle and halt falling edge.
    int          cyc = 0;
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          rst_q[$];
    int          last_wr_cyc = -1;
    int          halt_fall_cyc = -1;
    logic        prev_cs = 1'b0;
    logic        prev_halt = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (mem_cs === 1'b1) begin
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(mem_wdata);
            last_wr_cyc = cyc;
            checks++;
            if (mem_we !== 1'b1 || prev_cs) begin
                errors++;
                $display("FAIL write_strobe: we=%0b prev_cs=%0b, expected we=1 and single-cycle cs",
                         mem_we, prev_cs);
            end
        end
        if (cpu_rst === 1'b1) rst_q.push_back(cyc);
        if (prev_halt && cpu_halt === 1'b0) halt_fall_cyc = cyc;
        prev_cs   = (mem_cs === 1'b1);
        prev_halt = (cpu_halt === 1'b1);
    end

    logic [31:0] img [0:MW-1];

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        rst_q.delete();
        last_wr_cyc   = -1;
        halt_fall_cyc = -1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = !bad_stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    // Serialises count byte + nw words of img, MSB first, plus the XOR byte when enabled.
    task automatic send_image(input logic [7:0] nb, input int nw);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        send_byte(nb, 1'b0);
        for (int w = 0; w < nw; w++) begin
            for (int k = 3; k >= 0; k--) begin
                b  = img[w][8*k +: 8];
                cs = cs ^ b;
                send_byte(b, 1'b0);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        if (nw > 0) send_byte(cs, 1'b0);
`endif
    endtask

    task automatic wait_not_busy(input int budget);
        int k;
        k = 0;
        while (busy === 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        #1;
        chk("busy_drop_within_budget", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_load(input string tag, input int nw);
        wait_not_busy(200);
        settle(2);
        chk({tag, "_nwrites"}, wr_addr_q.size(), nw);
        if (wr_addr_q.size() == nw) begin
            for (int i = 0; i < nw; i++) begin
                chk({tag, "_addr"}, wr_addr_q[i], i);
                chk({tag, "_data"}, wr_data_q[i], img[i]);
            end
        end
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_halt"}, {31'd0, cpu_halt}, 32'd0);
        chk({tag, "_wl"}, {24'd0, words_loaded}, nw);
        chk({tag, "_rst_cycles"}, rst_q.size(), 2);
        if (rst_q.size() == 2) begin
            chk({tag, "_rst_consec"}, rst_q[1], rst_q[0] + 1);
            chk({tag, "_halt_fall"}, halt_fall_cyc, rst_q[0] + 2);
`ifndef LOADER_CHECKSUM_EN
            chk({tag, "_rst_after_write"}, rst_q[0], last_wr_cyc + 1);
`endif
        end
    endtask

    typedef struct {
        logic [7:0] cnt;
        int         nwords;
        logic       exp_err;
        logic       exp_halt;
        logic [7:0] exp_wl;
    } vec_t;

    vec_t vecs [0:6];

    initial begin
        vecs[0] = '{8'h00, 0, 1'b1, 1'b0, 8'd0};
        vecs[1] = '{8'h81, 0, 1'b1, 1'b0, 8'd0};
        vecs[2] = '{8'hFF, 0, 1'b1, 1'b0, 8'd0};
        vecs[3] = '{8'h01, 1, 1'b0, 1'b0, 8'd1};
        vecs[4] = '{8'h03, 3, 0, 1'b0, 8'd3};
        vecs[5] = '{8'h00, 0, 1'b1, 1'b0, 8'd3};
        vecs[6] = '{8'h02, 2, 1'b0, 1'b0, 8'd2};

        rx  = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        settle(6);
        chk("rst_halt",  {31'd0, cpu_halt}, 32'd0);
        chk("rst_cpurst", {31'd0, cpu_rst}, 32'd0);
        chk("rst_cs",    {31'd0, mem_cs}, 32'd0);
        chk("rst_we",    {31'd0, mem_we}, 32'd0);
        chk("rst_addr",  {25'd0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_err",   {31'd0, err}, 32'd0);
        chk("rst_wl",    {24'd0, words_loaded}, 32'd0);
        chk("rst_nwrites", wr_addr_q.size(), 0);

        // One-cycle low glitch must not yield a byte (an 0xFF byte would set err).
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        settle(14 * CPB);
        chk("glitch_err",  {31'd0, err}, 32'd0);
        chk("glitch_busy", {31'd0, busy}, 32'd0);
        chk("glitch_nwrites", wr_addr_q.size(), 0);

        foreach (vecs[v]) begin
            clear_mon();
            for (int i = 0; i < vecs[v].nwords; i++) img[i] = $urandom;
            send_image(vecs[v].cnt, vecs[v].nwords);
            if (vecs[v].nwords > 0) begin
                check_load($sformatf("vec%0d", v), vecs[v].nwords);
            end else begin
                settle(2 * CPB);
                chk($sformatf("vec%0d_nwrites", v), wr_addr_q.size(), 0);
            end
            chk($sformatf("vec%0d_err", v),  {31'd0, err}, {31'd0, vecs[v].exp_err});
            chk($sformatf("vec%0d_halt", v), {31'd0, cpu_halt}, {31'd0, vecs[v].exp_halt});
            chk($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd0);
            chk($sformatf("vec%0d_wl", v),   {24'd0, words_loaded}, {24'd0, vecs[v].exp_wl});
        end

        clear_mon();
        img[0] = 32'h2001_0005;
        send_image(8'h01, 1);
        check_load("single", 1);

        for (int r = 0; r < 3; r++) begin
            int n;
            n = $urandom_range(1, 16);
            clear_mon();
            for (int i = 0; i < n; i++) img[i] = $urandom;
            send_image(8'(n), n);
            check_load($sformatf("rand%0d", r), n);
        end

        clear_mon();
        for (int i = 0; i < MW; i++) img[i] = $urandom;
        send_image(8'h80, MW);
        check_load("full128", MW);

        // Framing error on byte 6 of a 2-word image: one write, halted, err set.
        clear_mon();
        for (int i = 0; i < 2; i++) img[i] = $urandom;
        send_byte(8'h02, 1'b0);
        for (int k = 3; k >= 0; k--) send_byte(img[0][8*k +: 8], 1'b0);
        send_byte(img[1][31:24], 1'b0);
        send_byte(img[1][23:16], 1'b1);
        settle(2 * CPB);
        chk("ferr_err",  {31'd0, err}, 32'd1);
        chk("ferr_halt", {31'd0, cpu_halt}, 32'd1);
        chk("ferr_busy", {31'd0, busy}, 32'd0);
        chk("ferr_cpurst_cycles", rst_q.size(), 0);
        chk("ferr_nwrites", wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) begin
            chk("ferr_addr", wr_addr_q[0], 0);
            chk("ferr_data", wr_data_q[0], img[0]);
        end
        clear_mon();
        img[0] = $urandom;
        send_image(8'h01, 1);
        check_load("after_ferr", 1);

`ifdef LOADER_CHECKSUM_EN
        clear_mon();
        img[0] = 32'h1234_5678;
        send_byte(8'h01, 1'b0);
        for (int k = 3; k >= 0; k--) send_byte(img[0][8*k +: 8], 1'b0);
        send_byte(8'h00, 1'b0);
        settle(2 * CPB);
        chk("csum_bad_err",  {31'd0, err}, 32'd1);
        chk("csum_bad_halt", {31'd0, cpu_halt}, 32'd1);
        chk("csum_bad_busy", {31'd0, busy}, 32'd0);
        chk("csum_bad_nwrites", wr_addr_q.size(), 1);
        chk("csum_bad_cpurst_cycles", rst_q.size(), 0);
`endif

        // Synchronous reset in the middle of L_DATA.
        clear_mon();
        send_byte(8'h02, 1'b0);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        #1;
        chk("midrst_pre_busy", {31'd0, busy}, 32'd1);
        chk("midrst_pre_halt", {31'd0, cpu_halt}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_halt", {31'd0, cpu_halt}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_err",  {31'd0, err}, 32'd0);
        chk("midrst_wl",   {24'd0, words_loaded}, 32'd0);
        rst = 1'b0;
        clear_mon();
        img[0] = $urandom;
        send_image(8'h01, 1);
        check_load("after_midrst", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mips_uart_loader.md
# mips_uart_loader

Program loader that sits directly upstream of the multicycle MIPS core and its 128-word instruction/data memory. It receives a program image over a UART RX line (8N1) and assembles the bytes into 32-bit words. While the CPU is held halted, it writes those words into memory from address 0 upward, then pulses a CPU reset and releases the halt so the new image runs from PC 0.

## Interface
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be ≥ 4
- MEM_WORDS, 128, memory depth in words; the maximum accepted word count

- clk  in  1  system clock; must also clock the memory during a load
- rst  in  1  reset, synchronous, active-high
- rx  in  1  asynchronous UART serial input; idles high
- cpu_halt  out  1  drives CPU HALT; high while a load is in progress or after an aborted load
- cpu_rst  out  1  drives CPU RST; 2-cycle pulse after a successful load
- mem_cs  out  1  memory chip select; high only in the write cycle
- mem_we  out  1  memory write enable; equals mem_cs
- mem_addr  out  7  word address being written
- mem_wdata  out  32  word to write; external logic muxes it onto Mem_Bus when mem_we=1
- busy  out  1  high from acceptance of the count byte until return to L_IDLE
- err  out  1  sticky load error
- words_loaded  out  8  words written in the current or most recent load

## Operation
- Reset: all outputs 0, the UART receiver idles, and the loader is in L_IDLE.
- RX front end:
  - rx is synchronised through 2 flops.
  - In idle, a falling edge starts a byte. The start bit is re-sampled after CLKS_PER_BIT/2 cycles; if it is high, the edge is treated as a glitch and the receiver returns to idle.
  - 8 data bits are then sampled, LSB first, every CLKS_PER_BIT cycles, followed by the stop bit.
  - Stop bit high: byte_valid pulses for 1 cycle. Stop bit low: ferr pulses for 1 cycle.
- Image format: 1 count byte N (1..MEM_WORDS), then 4·N data bytes. Each word is sent MSB first.
- Loader FSM:
  - L_IDLE: waits for byte_valid.
    - N=0 or N>MEM_WORDS: err=1, byte ignored, stay in L_IDLE.
    - Otherwise: cpu_halt=1, busy=1, err=0, words_loaded=0, mem_addr=0, go to L_DATA.
  - L_DATA: shift each byte into a 32-bit register (word = {word[23:0], byte}). On the 4th byte, go to L_WRITE.
  - L_WRITE: exactly 1 cycle with mem_cs=mem_we=1, mem_addr and mem_wdata stable. Next cycle: mem_addr+1, words_loaded+1. If words_loaded reaches N go to L_RELEASE, else go to L_DATA.
  - L_RELEASE: cpu_rst=1 for 2 cycles while cpu_halt stays 1. Then cpu_halt=0, busy=0, go to L_IDLE.
- Framing error while busy: abort to L_IDLE with err=1 and cpu_halt held at 1, so a partial image never runs. A new valid count byte restarts the load. A framing error in L_IDLE only sets err.
- Writes never exceed address N-1; mem_addr never wraps within a load.

## Timing
- Byte latency: byte_valid occurs about 9.5·CLKS_PER_BIT cycles after the start edge, at mid-stop-bit.
- Write latency: the L_WRITE cycle is the cycle after the byte_valid of the 4th byte of a word. The memory captures the word on the falling clk edge inside that cycle.
- Release sequence after the last L_WRITE cycle:
  - cpu_rst high on cycles +1 and +2
  - cpu_halt falls on cycle +3
- rst mid-load: immediate return to L_IDLE with all outputs 0. Memory contents are left as partially written.
- Simultaneous events: a byte arriving in the L_WRITE or L_RELEASE cycles cannot occur, since a byte takes at least 9·CLKS_PER_BIT cycles. The receiver always keeps running, so the next start bit is never missed.

## Configuration
- Macro: LOADER_CHECKSUM_EN
- Defined:
  - After N words, one extra byte is expected: the XOR of all 4·N data bytes.
  - Match: proceed to L_RELEASE.
  - Mismatch: err=1, cpu_halt held at 1, return to L_IDLE.
  - L_WRITE still goes to L_DATA after the final word; the checksum byte is received there.
- Undefined: no checksum byte; L_RELEASE follows the final write directly.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset: rst for 2 cycles, then hold rx=1 → all outputs 0, no mem_cs activity.
- Single word: send 0x01, then 0x20,0x01,0x00,0x05 (plus checksum 0x24 with the macro) → one write, addr 0, data 0x20010005. cpu_rst high for 2 cycles, then cpu_halt=0 and words_loaded=1.
- 128 words: send 0x80 + 512 bytes → 128 single-cycle writes at addresses 0..127 in order, mem_addr never 0 again, then release.
- Bad count: send 0x00, then 0x81 → err=1, cpu_halt=0, no writes.
- Framing error: send 0x02 + 5 bytes, then corrupt the stop bit of byte 6 → one write at addr 0, err=1, cpu_halt stays 1. A following valid 0x01 load clears err and completes normally.
- Glitch and reset: a 1-cycle low pulse on rx produces no byte. Asserting rst during L_DATA → cpu_halt=0, busy=0 on the next cycle.
